// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin sharing of one UART transmitter between NUM_REQ byte sources
module uart_tx_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int DATA_BITS = 8,
  parameter int START_TIMEOUT = 16
) (
  input  logic                           Clk,
  input  logic                           Rst,
  input  logic [NUM_REQ-1:0]             Req,
  input  logic [NUM_REQ*DATA_BITS-1:0]   Req_Data,
  input  logic                           Pause,
  input  logic                           Tx_Busy,
  output logic [DATA_BITS-1:0]           Tx_Data,
  output logic                           Transmit_Start,
  output logic [NUM_REQ-1:0]             Grant,
  output logic [$clog2(NUM_REQ)-1:0]     Grant_Id,
  output logic                           Arb_Busy,
  output logic                           Done,
  output logic                           Timeout_Err
);
  localparam int IW = $clog2(NUM_REQ);
  localparam int CW = $clog2(START_TIMEOUT);
  localparam logic [CW-1:0] LAST = CW'(START_TIMEOUT - 1);
  typedef enum logic [1:0] {IDLE, START, SENDING} state_t;
  state_t state, state_d;
  logic [IW-1:0] rr_ptr, win, nxt_ptr;
  logic [CW-1:0] cnt;
  logic found, go, fire_to, fire_done;
  int idx;
  // Scan downwards so the lowest offset from rr_ptr is written last and wins.
  always_comb begin
    win = rr_ptr;
    found = 1'b0;
    idx = 0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      idx = int'(rr_ptr) + i;
      idx = idx >= NUM_REQ ? idx - NUM_REQ : idx;
      if (Req[idx]) begin
        win = IW'(idx);
        found = 1'b1;
      end
    end
  end
  always_comb begin
    nxt_ptr = Grant_Id == IW'(NUM_REQ - 1) ? '0 : Grant_Id + 1'b1;
    go = state == IDLE && !Pause && !Tx_Busy && found;
    fire_to = state == START && !Tx_Busy && cnt == LAST;
    fire_done = state == SENDING && !Tx_Busy;
    state_d = go ? START
            : (state == START && Tx_Busy) ? SENDING
            : (fire_to || fire_done) ? IDLE
            : state;
  end
  assign Arb_Busy = state != IDLE;
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state <= IDLE;
      Tx_Data <= '0;
      Transmit_Start <= 1'b0;
      Grant <= '0;
      Grant_Id <= '0;
      Done <= 1'b0;
      Timeout_Err <= 1'b0;
      rr_ptr <= '0;
      cnt <= '0;
    end else begin
      state <= state_d;
      Transmit_Start <= state_d == START;
      Grant <= go ? NUM_REQ'(1) << win : '0;
      Done <= fire_done;
      Timeout_Err <= fire_to;
      if (go) begin
        Tx_Data <= Req_Data[int'(win)*DATA_BITS +: DATA_BITS];
        Grant_Id <= win;
        cnt <= '0;
      end else if (state == START) begin
        cnt <= cnt + 1'b1;
      end
      if (fire_to || fire_done) rr_ptr <= nxt_ptr;
    end
  end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: scenario tasks against a simple UART busy model and a grant scoreboard
module tb_uart_tx_arbiter;
  localparam int N = 4;
  localparam int FRAME = 11;
  logic Clk = 0, Rst = 1, Pause = 0;
  logic [N-1:0] Req = '0;
  logic [N*8-1:0] Req_Data = '0;
  logic [7:0] Tx_Data;
  logic Transmit_Start, Arb_Busy, Done, Timeout_Err;
  logic [N-1:0] Grant;
  logic [1:0] Grant_Id;
  logic tb_busy = 0, uart_dead = 0;
  int left = 0;
  int checks = 0, passes = 0;
  typedef struct packed {logic [1:0] id; logic [7:0] d;} exp_t;
  exp_t exp_q[$];

  uart_tx_arbiter #(.NUM_REQ(N), .DATA_BITS(8), .START_TIMEOUT(16)) dut (
    .Clk(Clk), .Rst(Rst), .Req(Req), .Req_Data(Req_Data), .Pause(Pause), .Tx_Busy(tb_busy),
    .Tx_Data(Tx_Data), .Transmit_Start(Transmit_Start), .Grant(Grant), .Grant_Id(Grant_Id),
    .Arb_Busy(Arb_Busy), .Done(Done), .Timeout_Err(Timeout_Err));

  always #5 Clk = ~Clk;

  // UART stand-in: goes busy on the edge it sees Transmit_Start, stays busy for FRAME cycles.
  always @(posedge Clk) begin
    if (tb_busy) begin
      if (left == 0) tb_busy <= 0;
      else left <= left - 1;
    end else if (Transmit_Start && !uart_dead) begin
      tb_busy <= 1;
      left <= FRAME - 1;
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic set_data(input logic [7:0] d0, d1, d2, d3);
    Req_Data = {d3, d2, d1, d0};
  endtask

  task automatic do_reset();
    Rst = 1;
    repeat (2) @(negedge Clk);
    Rst = 0;
  endtask

  task automatic wait_grant(input int limit);
    bit got = 0;
    exp_t e;
    for (int n = 0; n < limit && !got; n++) begin
      @(negedge Clk);
      got = Grant != 0;
    end
    checks++;
    if (!got) $display("FAIL grant_wait: no Grant within %0d cycles", limit);
    else if (exp_q.size() == 0) $display("FAIL grant_unexpected: Grant=%b with nothing expected", Grant);
    else begin
      e = exp_q.pop_front();
      if (Grant !== N'(1) << e.id || Grant_Id !== e.id || Tx_Data !== e.d || Transmit_Start !== 1'b1 || Done !== 1'b0)
        $display("FAIL grant: Grant=%b id=%0d data=%h start=%b done=%b, expected Grant=%b id=%0d data=%h start=1 done=0",
                 Grant, Grant_Id, Tx_Data, Transmit_Start, Done, N'(1) << e.id, e.id, e.d);
      else passes++;
    end
  endtask

  task automatic wait_done(input int limit);
    bit got = 0;
    for (int n = 0; n < limit && !got; n++) begin
      @(negedge Clk);
      got = Done === 1'b1;
    end
    checks++;
    if (!got) $display("FAIL done_wait: no Done within %0d cycles", limit);
    else if (Grant !== '0 || Arb_Busy !== 1'b0)
      $display("FAIL done: Grant=%b Arb_Busy=%b with Done, expected 0000 and 0", Grant, Arb_Busy);
    else passes++;
  endtask

  task automatic count_start(input int expected);
    int n = 1;
    while (n < 100) begin
      @(negedge Clk);
      if (!Transmit_Start) break;
      n++;
    end
    checks++;
    if (n !== expected) $display("FAIL start_len: Transmit_Start high %0d cycles, expected %0d", n, expected);
    else passes++;
  endtask

  task automatic test_reset();
    Rst = 1;
    repeat (3) @(negedge Clk);
    checks++;
    if ({Tx_Data, Transmit_Start, Grant, Grant_Id, Arb_Busy, Done, Timeout_Err} !== '0)
      $display("FAIL reset: data=%h start=%b grant=%b id=%0d busy=%b done=%b to=%b, expected all 0",
               Tx_Data, Transmit_Start, Grant, Grant_Id, Arb_Busy, Done, Timeout_Err);
    else passes++;
    Rst = 0;
  endtask

  task automatic test_single();
    set_data(8'hA5, 8'h00, 8'h00, 8'h00);
    Req = 4'b0001;
    exp_q.push_back({2'd0, 8'hA5});
    wait_grant(5);
    Req = '0;
    count_start(2);
    wait_done(30);
    checks++;
    if (Grant_Id !== 2'd0) $display("FAIL single_id: Grant_Id=%0d, expected 0", Grant_Id);
    else passes++;
  endtask

  task automatic test_round_robin();
    do_reset();
    set_data(8'h10, 8'h21, 8'h32, 8'h43);
    Req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      exp_q.push_back({2'(k % 4), 8'h10 + 8'h11 * 8'(k % 4)});
      wait_grant(k == 0 ? 5 : 1);
      if (k == 4) Req = '0;
      wait_done(30);
    end
  endtask

  task automatic test_wrap();
    set_data(8'h5A, 8'h6B, 8'h00, 8'h00);
    Req = 4'b0010;
    exp_q.push_back({2'd1, 8'h6B});
    wait_grant(3);
    Req = '0;
    wait_done(30);
    Req = 4'b0011;
    exp_q.push_back({2'd0, 8'h5A});
    exp_q.push_back({2'd1, 8'h6B});
    wait_grant(3);
    Req = 4'b0010;
    wait_done(30);
    wait_grant(1);
    Req = '0;
    wait_done(30);
  endtask

  task automatic test_timeout();
    uart_dead = 1;
    set_data(8'h00, 8'h00, 8'hC3, 8'hD4);
    Req = 4'b0100;
    exp_q.push_back({2'd2, 8'hC3});
    wait_grant(3);
    Req = '0;
    count_start(16);
    checks++;
    if (Timeout_Err !== 1'b1 || Arb_Busy !== 1'b0 || Done !== 1'b0)
      $display("FAIL timeout_pulse: Timeout_Err=%b Arb_Busy=%b Done=%b, expected 1 0 0", Timeout_Err, Arb_Busy, Done);
    else passes++;
    @(negedge Clk);
    checks++;
    if (Timeout_Err !== 1'b0) $display("FAIL timeout_once: Timeout_Err=%b, expected 0", Timeout_Err);
    else passes++;
    uart_dead = 0;
    Req = 4'b1100;
    exp_q.push_back({2'd3, 8'hD4});
    wait_grant(1);
    Req = '0;
    wait_done(30);
  endtask

  task automatic test_pause();
    int bad = 0;
    set_data(8'h00, 8'h77, 8'h00, 8'h00);
    Pause = 1;
    Req = 4'b0010;
    repeat (50) begin
      @(negedge Clk);
      if (Grant !== '0 || Arb_Busy !== 1'b0) bad++;
    end
    checks++;
    if (bad !== 0) $display("FAIL pause_hold: %0d cycles with Grant or Arb_Busy, expected 0", bad);
    else passes++;
    Pause = 0;
    exp_q.push_back({2'd1, 8'h77});
    wait_grant(1);
    Req = '0;
    count_start(2);
    Pause = 1;
    wait_done(30);
    Pause = 0;
  endtask

  task automatic test_reset_mid();
    int bad = 0;
    set_data(8'h3C, 8'h00, 8'h99, 8'h00);
    Req = 4'b0001;
    exp_q.push_back({2'd0, 8'h3C});
    wait_grant(3);
    Req = '0;
    count_start(2);
    repeat (3) @(negedge Clk);
    Rst = 1;
    #1;
    checks++;
    if ({Tx_Data, Transmit_Start, Grant, Grant_Id, Arb_Busy, Done, Timeout_Err} !== '0)
      $display("FAIL reset_mid: data=%h start=%b grant=%b id=%0d busy=%b done=%b to=%b, expected all 0",
               Tx_Data, Transmit_Start, Grant, Grant_Id, Arb_Busy, Done, Timeout_Err);
    else passes++;
    @(negedge Clk);
    Rst = 0;
    Req = 4'b0101;
    exp_q.push_back({2'd0, 8'h3C});
    for (int n = 0; n < 100 && tb_busy; n++) begin
      @(negedge Clk);
      if (Grant !== '0 || Done !== 1'b0) bad++;
    end
    checks++;
    if (bad !== 0 || tb_busy) $display("FAIL reset_wait: %0d cycles with Grant/Done while Tx_Busy high, expected 0", bad);
    else passes++;
    wait_grant(1);
    Req = '0;
    wait_done(30);
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_wrap();
    test_timeout();
    test_pause();
    test_reset_mid();
    checks++;
    if (exp_q.size() !== 0) $display("FAIL scoreboard_left: %0d expected grants never seen, expected 0", exp_q.size());
    else passes++;
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
Round-robin arbiter that shares the single UART transmitter between NUM_REQ byte sources, such as a command path, status reporter or debug port.
It sits between the requesters and the UART's Tx_Data / Transmit_Start / Tx_Busy port.
It captures the winning requester's byte, sequences the Transmit_Start handshake, and holds off further grants until the frame is finished.
A start-timeout guard stops a dead or BIST-occupied transmitter from locking up the arbiter.

Parameters:
NUM_REQ, 4, number of requesters (2..16)
DATA_BITS, 8, UART data width; must match the UART instance
START_TIMEOUT, 16, Clk cycles Transmit_Start may stay high without Tx_Busy rising before the attempt is abandoned (>=2)

Ports:
Clk  input  1  baud-rate clock shared with the UART
Rst  input  1  asynchronous, active-high reset
Req  input  NUM_REQ  per-requester send request; held until the matching Grant bit pulses
Req_Data  input  NUM_REQ*DATA_BITS  packed bytes; requester i uses bits [i*DATA_BITS +: DATA_BITS]; must be stable while Req[i] is high
Pause  input  1  when high, no new grant is issued; an in-flight frame still completes
Tx_Busy  input  1  from the UART: transmitter busy
Tx_Data  output  DATA_BITS  byte presented to the UART; registered
Transmit_Start  output  1  to the UART; registered
Grant  output  NUM_REQ  one-hot, 1-cycle pulse: this requester's byte has been captured
Grant_Id  output  $clog2(NUM_REQ)  index of the current or last winner
Arb_Busy  output  1  high in every state except IDLE
Done  output  1  1-cycle pulse when the granted frame completes (Tx_Busy falls)
Timeout_Err  output  1  1-cycle pulse when the start attempt is abandoned

Behaviour:
- Reset:
  - Asserting Rst at any time, including mid-frame, immediately forces state to IDLE.
  - Tx_Data, Transmit_Start, Grant, Grant_Id, Arb_Busy, Done, Timeout_Err, Rr_Ptr and the timeout counter all go to 0.
  - A frame already started inside the UART is not aborted; after reset the arbiter waits in IDLE for Tx_Busy low before the next grant.
- States: IDLE, START, SENDING.
- IDLE:
  - A grant is issued when Pause==0, Tx_Busy==0 and |Req.
  - Winner = first index k, scanning Rr_Ptr, Rr_Ptr+1, ... modulo NUM_REQ, with Req[k]==1.
  - On the next edge: Tx_Data<=Req_Data[k], Grant_Id<=k, Grant[k] pulses for 1 cycle, counter<=0, state->START.
  - Transmit_Start rises on that same edge.
- START:
  - Transmit_Start is held high and the counter increments each cycle.
  - If Tx_Busy==1: Transmit_Start<=0, state->SENDING.
  - Otherwise, when counter==START_TIMEOUT-1: Transmit_Start<=0, Timeout_Err pulses, Rr_Ptr<=Grant_Id+1 mod NUM_REQ, state->IDLE.
  - The timed-out byte is dropped; the requester must re-request.
- SENDING:
  - Wait for Tx_Busy==0.
  - Then Done pulses, Rr_Ptr<=Grant_Id+1 mod NUM_REQ, state->IDLE.
- Fairness:
  - Rr_Ptr only advances on Done or Timeout_Err.
  - A requester holding Req continuously gets at most one frame before every other active requester is served.
- Back-to-back:
  - Minimum gap is 1 cycle: Done in cycle n, IDLE evaluates in cycle n+1, and Grant/Transmit_Start is issued at the n+1 edge.
- Req behaviour:
  - Dropping Req before Grant withdraws the request without side effects.
  - Req changes during START/SENDING are ignored until IDLE.
- Pause:
  - Sampled only in IDLE.
  - Pause rising during START/SENDING has no effect on that frame.
- NUM_REQ not a power of two: wrap is explicit (index == NUM_REQ-1 -> 0); the pointer never holds an out-of-range value.
- Grant and Done are mutually exclusive within any cycle.
- Arb_Busy is a decode of state (IDLE -> 0).

Test Plan:
- Reset, then Req=4'b0001 with byte 0xA5 and a UART model raising Tx_Busy 2 cycles after start -> Grant=0001 for 1 cycle; Tx_Data=0xA5; Transmit_Start high for exactly 2 cycles; frame on Tx {0,A5,parity 0,11}; Done after Tx_Busy falls; Grant_Id=0.
- Req=4'b1111 held, bytes 0x10/0x21/0x32/0x43 -> grant order 0,1,2,3,0; captured Tx_Data sequence 10,21,32,43,10; every Grant pulse preceded by Done.
- Rr_Ptr=2 (after serving req 1), then Req=4'b0011 -> req 0 wins (wrap); next grant goes to req 1.
- Tx_Busy tied low, Req=4'b0100 -> Transmit_Start high for exactly 16 cycles; Timeout_Err pulses once; state IDLE; next grant goes to req 3 if requesting, else back to req 2.
- Pause=1 with Req=4'b0010 -> no Grant for 50 cycles; Pause=0 -> Grant=0010 on the next edge. Pause raised during SENDING -> the frame completes and Done pulses.
- Rst pulsed mid-SENDING -> all outputs 0 immediately, Rr_Ptr=0; no grant while Tx_Busy stays high; after Tx_Busy falls, a pending Req[0] gets Grant.
